mem_wb_unit: RTL
================

Name: mem_wb_unit

Overview:
Memory-access and write-back stage of the ARM-subset pipeline, sitting between the EXE stage and the register-file write port of the decode stage. It performs loads and stores through a ready-handshaked data memory and freezes the upstream pipeline while an access is outstanding. It drives the write-back triple WB_WB_EN / WB_WB_value / WB_WB_dest consumed by the decode stage's register file.

Parameters:
ADDR_BASE, 1024, byte address subtracted from ALU result to form the data-memory address
MEM_ADDR_W, 16, width of word address to data memory
TIMEOUT, 255, max WAIT cycles before abort; 0 disables the watchdog

Ports:
clk  in  1  pipeline clock
rst  in  1  synchronous reset, active-high
exe_alu_result  in  32  ALU result / effective byte address
exe_val_rm  in  32  store data
exe_dest  in  4  destination register
exe_wb_en  in  1  instruction writes back
exe_mem_r_en  in  1  load
exe_mem_w_en  in  1  store
mem_req  out  1  access request to data memory
mem_we  out  1  1 = write, 0 = read
mem_addr  out  MEM_ADDR_W  word address
mem_wdata  out  32  store data
mem_rdata  in  32  load data, valid when mem_ready
mem_ready  in  1  access complete (one-cycle pulse)
freeze  out  1  stall IF/ID/EXE and their pipeline registers
mem_err  out  1  sticky watchdog-abort flag
WB_WB_EN  out  1  register-file write enable
WB_WB_value  out  32  write-back data
WB_WB_dest  out  4  write-back register index

Behaviour:
- Reset (synchronous, active-high): state=IDLE; mem_req, mem_we, WB_WB_EN, mem_err = 0; mem_addr, mem_wdata, WB_WB_value, WB_WB_dest = 0; watchdog counter = 0. Reset during WAIT aborts the access; mem_req drops at the next cycle.
- FSM states: IDLE, WAIT.
- IDLE, no memory op (exe_mem_r_en=exe_mem_w_en=0): freeze=0; at the edge, WB_WB_EN<=exe_wb_en, WB_WB_value<=exe_alu_result, WB_WB_dest<=exe_dest. Latency is 1 cycle.
- IDLE, memory op: freeze=1 (combinational) and WB_WB_EN<=0 (bubble). Latch mem_addr<=((exe_alu_result-ADDR_BASE)>>2) truncated to MEM_ADDR_W, mem_wdata<=exe_val_rm, mem_we<=exe_mem_w_en, dest and wb_en. Go to WAIT.
- Both r_en and w_en set: store takes priority (mem_we=1) and write-back is suppressed.
- WAIT: mem_req=1 with address, data and we held stable. freeze = !mem_ready. The upstream holds EXE inputs stable while frozen. WB_WB_EN=0 each frozen cycle.
- WAIT & mem_ready: at that edge the state goes to IDLE and mem_req<=0. For a load, WB_WB_EN<=latched wb_en, WB_WB_value<=mem_rdata, WB_WB_dest<=latched dest. For a store, WB_WB_EN<=0. Upstream advances on the same edge, so there is no extra bubble.
- Minimum load/store latency: 2 cycles (detect + one WAIT), i.e. data appears on the write-back outputs 2 edges after the op enters the stage.
- mem_ready outside WAIT: ignored.
- Watchdog (TIMEOUT>0): the counter increments each WAIT cycle without ready. When it reaches TIMEOUT: abort (IDLE, mem_req=0, WB_WB_EN=0, freeze=0) and set mem_err=1, which holds until rst. The counter clears on entry to WAIT.
- Address arithmetic: 32-bit modular subtraction, so an ALU result below ADDR_BASE wraps. Byte offset [1:0] is discarded.
- WB outputs are registered. They hold their value when freeze=1, except WB_WB_EN, which is 0 during frozen cycles.

Decomposition:
- Shared pipeline package: state enum {IDLE, WAIT}, ADDR_BASE default, register-index width (4), data width (32).
- One natural sub-module: mem_wb_reg, the MEM/WB output register (en/value/dest) with sync reset and a bubble-insert input.

Test Plan:
- ALU op: alu=0x00000005, dest=3, wb_en=1 -> next cycle WB_WB_EN=1, value=5, dest=3; freeze never set.
- Load, ready after 3 WAIT cycles: alu=1028, rdata=0xDEADBEEF, dest=7 -> mem_addr=1, mem_we=0; freeze high 3 cycles; then WB_WB_EN=1, value=0xDEADBEEF, dest=7.
- Store with same-cycle ready: alu=1032, val_rm=0x12345678 -> mem_addr=2, mem_we=1, wdata=0x12345678; freeze for 1 cycle; WB_WB_EN=0.
- Back-to-back load then ALU op -> ALU result is written back exactly one cycle after the load's write-back, with no lost or duplicated instruction.
- Watchdog with TIMEOUT=4 and no ready -> abort after 4 WAIT cycles; mem_err=1 and sticky; freeze=0; WB_WB_EN=0.
- rst asserted in the 2nd WAIT cycle -> next cycle mem_req=0, state IDLE, all outputs 0; a later stray mem_ready is ignored.

Source files
------------

// File: rtl/mem_wb_pkg.sv
// Shared definitions for the memory-access / write-back stage.
package mem_wb_pkg;
    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    localparam int ADDR_BASE_DEF = 1024;
    localparam int REG_W         = 4;
    localparam int DATA_W        = 32;
endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB output register. A bubble clears the enable but keeps value/dest.
module mem_wb_reg
    import mem_wb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_bubble,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_value,
    input  logic [REG_W-1:0]  i_dest,
    output logic              o_en,
    output logic [DATA_W-1:0] o_value,
    output logic [REG_W-1:0]  o_dest
);
    logic              r_en;
    logic [DATA_W-1:0] r_value;
    logic [REG_W-1:0]  r_dest;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_en    <= 1'b0;
            r_value <= '0;
            r_dest  <= '0;
        end else if (i_bubble) begin
            r_en    <= 1'b0;
        end else begin
            r_en    <= i_en;
            r_value <= i_value;
            r_dest  <= i_dest;
        end
    end

    assign o_en    = r_en;
    assign o_value = r_value;
    assign o_dest  = r_dest;
endmodule

// File: rtl/mem_wb_unit.sv
// Memory-access and write-back stage: issues one data-memory access per
// load/store, freezes upstream while it is outstanding, drives the RF write port.
module mem_wb_unit
    import mem_wb_pkg::*;
#(
    parameter int ADDR_BASE  = ADDR_BASE_DEF,
    parameter int MEM_ADDR_W = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     exe_alu_result,
    input  logic [DATA_W-1:0]     exe_val_rm,
    input  logic [REG_W-1:0]      exe_dest,
    input  logic                  exe_wb_en,
    input  logic                  exe_mem_r_en,
    input  logic                  exe_mem_w_en,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_ready,
    output logic                  freeze,
    output logic                  mem_err,
    output logic                  WB_WB_EN,
    output logic [DATA_W-1:0]     WB_WB_value,
    output logic [REG_W-1:0]      WB_WB_dest
);
    localparam int CNT_W = $clog2(TIMEOUT + 2);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [MEM_ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0]     r_mem_wdata;
    logic                  r_mem_we;
    logic [REG_W-1:0]      r_dest;
    logic                  r_wb_en;
    logic [CNT_W-1:0]      r_wd_cnt;
    logic                  r_mem_err;

    logic                  w_mem_op;
    logic                  w_timeout;
    logic                  w_bubble;
    logic                  w_wb_en;
    logic [DATA_W-1:0]     w_wb_value;
    logic [REG_W-1:0]      w_wb_dest;

    assign w_mem_op = exe_mem_r_en | exe_mem_w_en;

    // Abort fires during the TIMEOUT-th ready-less WAIT cycle; freeze drops in
    // that same cycle so upstream retires the failed op instead of reissuing it.
    assign w_timeout = (TIMEOUT != 0) && (r_state == WAIT) && !mem_ready &&
                       (r_wd_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_mem_op) w_state_nxt = WAIT;
            WAIT:    if (mem_ready || w_timeout) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_req    = 1'b0;
        freeze     = 1'b0;
        w_bubble   = 1'b1;
        w_wb_en    = 1'b0;
        w_wb_value = exe_alu_result;
        w_wb_dest  = exe_dest;
        case (r_state)
            IDLE: begin
                freeze = w_mem_op;
                if (!w_mem_op) begin
                    w_bubble = 1'b0;
                    w_wb_en  = exe_wb_en;
                end
            end
            WAIT: begin
                mem_req = 1'b1;
                freeze  = !(mem_ready || w_timeout);
                if (mem_ready && !r_mem_we) begin
                    w_bubble   = 1'b0;
                    w_wb_en    = r_wb_en;
                    w_wb_value = mem_rdata;
                    w_wb_dest  = r_dest;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
            r_dest      <= '0;
            r_wb_en     <= 1'b0;
            r_wd_cnt    <= '0;
            r_mem_err   <= 1'b0;
        end else begin
            if (r_state == IDLE && w_mem_op) begin
                // Modular subtract: addresses below the base wrap around.
                r_mem_addr  <= MEM_ADDR_W'((exe_alu_result - 32'(ADDR_BASE)) >> 2);
                r_mem_wdata <= exe_val_rm;
                r_mem_we    <= exe_mem_w_en;
                r_dest      <= exe_dest;
                r_wb_en     <= exe_wb_en & ~exe_mem_w_en;
                r_wd_cnt    <= '0;
            end else if (r_state == WAIT && !mem_ready) begin
                r_wd_cnt    <= r_wd_cnt + CNT_W'(1);
            end
            if (w_timeout) r_mem_err <= 1'b1;
        end
    end

    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_err   = r_mem_err;

    mem_wb_reg u_wb_reg (
        .clk      (clk),
        .rst      (rst),
        .i_bubble (w_bubble),
        .i_en     (w_wb_en),
        .i_value  (w_wb_value),
        .i_dest   (w_wb_dest),
        .o_en     (WB_WB_EN),
        .o_value  (WB_WB_value),
        .o_dest   (WB_WB_dest)
    );
endmodule
